pe_depacketizer: RTL and testbench

- Receives NoC packets addressed to one PE, checks the destination, decodes the packet type and tags each filter row with its row index (0/1/2).
- Presents data, ifmap/filter flag and row index as one valid/ready output bundle to the PE split stage, which routes ifmap data or filter rows 1-3.
- A 2-entry output FIFO decouples NoC backpressure from the PE.
- Single clock. Reset is synchronous and active-high.

---
 rtl/pe_depacketizer_if.sv | 27 ++
 rtl/pe_depacketizer.sv | 111 +++++++++++
 tb/tb_pe_depacketizer.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_depacketizer_if.sv
// Packet-in / entry-out handshake bundle between the NoC side and the PE split stage.
// The master side drives packets and downstream ready; the depacketizer is the slave.
interface pe_depacketizer_if #(
    parameter int FILTER_WIDTH = 8,
    parameter int ADDR_WIDTH   = 4
);
    localparam int PKT_WIDTH = ADDR_WIDTH + 1 + 3 * FILTER_WIDTH;

    logic [PKT_WIDTH-1:0]      pkt_in;
    logic                      in_valid;
    logic                      in_ready;
    logic [3*FILTER_WIDTH-1:0] data_out;
    logic                      ifmapb_filter_out;
    logic [1:0]                filter_row_out;
    logic                      out_valid;
    logic                      out_ready;

    modport master (
        output pkt_in, in_valid, out_ready,
        input  in_ready, data_out, ifmapb_filter_out, filter_row_out, out_valid
    );

    modport slave (
        input  pkt_in, in_valid, out_ready,
        output in_ready, data_out, ifmapb_filter_out, filter_row_out, out_valid
    );
endinterface

// File: rtl/pe_depacketizer.sv
// Destination check, packet-type decode and filter-row tagging for one PE, with a
// 2-entry output FIFO whose head is copied into registered outputs.
module pe_depacketizer #(
    parameter int FILTER_WIDTH = 8,
    parameter int ADDR_WIDTH   = 4,
    parameter int PE_ADDR      = 0,
    parameter int PKT_WIDTH    = ADDR_WIDTH + 1 + 3 * FILTER_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    pe_depacketizer_if.slave      bus,
    output logic                  filter_done,
    output logic [7:0]            drop_cnt
);
    localparam int PAY_W = 3 * FILTER_WIDTH;
    localparam int ENT_W = PAY_W + 3;
    localparam logic [PAY_W-1:0]      IFMAP_MASK = PAY_W'(9'h1FF);
    localparam logic [ADDR_WIDTH-1:0] MY_ADDR    = ADDR_WIDTH'(PE_ADDR);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [ADDR_WIDTH-1:0] dst;
    logic                  pkt_type;
    logic [PAY_W-1:0]      payload;

    logic [ENT_W-1:0] mem [2];
    logic             rd_ptr, wr_ptr, rd_nxt;
    logic [1:0]       count, count_nxt;
    logic [1:0]       row_cnt;

    logic             accept, addr_hit, push, pop;
    logic [ENT_W-1:0] entry, head_nxt;

    assign dst      = bus.pkt_in[PKT_WIDTH-1 -: ADDR_WIDTH];
    assign pkt_type = bus.pkt_in[PAY_W];
    assign payload  = bus.pkt_in[PAY_W-1:0];

    // A pop in the same cycle frees a slot, so a full FIFO can still take a packet.
    assign bus.in_ready = !rst && ((count < 2'd2) || (bus.out_valid && bus.out_ready));

    assign accept   = bus.in_valid && bus.in_ready;
    assign addr_hit = (dst == MY_ADDR);
    assign push     = accept && addr_hit;
    assign pop      = bus.out_valid && bus.out_ready && !rst;

    always_comb begin
        if (pkt_type) begin
            entry = {payload, 1'b1, row_cnt};
        end else begin
            entry = {payload & IFMAP_MASK, 1'b0, 2'd0};
        end
    end

    // Next head: the incoming entry bypasses storage when it lands at the new read slot.
    always_comb begin
        rd_nxt    = pop ? ~rd_ptr : rd_ptr;
        count_nxt = count + 2'(push) - 2'(pop);
        if (push && (wr_ptr == rd_nxt)) begin
            head_nxt = entry;
        end else begin
            head_nxt = mem[rd_nxt];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr                <= 1'b0;
            wr_ptr                <= 1'b0;
            count                 <= 2'd0;
            row_cnt               <= 2'd0;
            filter_done           <= 1'b0;
            drop_cnt              <= 8'd0;
            bus.out_valid         <= 1'b0;
            bus.data_out          <= '0;
            bus.ifmapb_filter_out <= 1'b0;
            bus.filter_row_out    <= 2'd0;
        end else begin
            rd_ptr        <= rd_nxt;
            wr_ptr        <= push ? ~wr_ptr : wr_ptr;
            count         <= count_nxt;
            bus.out_valid <= (count_nxt != 2'd0);
            if (count_nxt != 2'd0) begin
                {bus.data_out, bus.ifmapb_filter_out, bus.filter_row_out} <= head_nxt;
            end

            filter_done <= push && pkt_type && (row_cnt == 2'd2);
            if (push && pkt_type) begin
                row_cnt <= (row_cnt == 2'd2) ? 2'd0 : row_cnt + 2'd1;
            end

            if (accept && !addr_hit) begin
                drop_cnt <= sat_inc(drop_cnt);
            end
        end
    end

    a_no_overflow : assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (count == 2'd2)));
    a_no_underflow : assert property (@(posedge clk) disable iff (rst)
        pop |-> (count != 2'd0));
    a_count_range : assert property (@(posedge clk) disable iff (rst)
        count <= 2'd2);
endmodule

// File: tb/tb_pe_depacketizer.sv
// Randomized and directed bench for pe_depacketizer with a queue-based reference model.
module tb_pe_depacketizer;
    localparam int FW = 8;
    localparam int AW = 4;
    localparam int PA = 0;
    localparam int DW = 3 * FW;
    localparam int PW = AW + 1 + DW;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          flag;
        logic [1:0]    row;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       filter_done;
    logic [7:0] drop_cnt;

    always #5 clk = ~clk;

    pe_depacketizer_if #(.FILTER_WIDTH(FW), .ADDR_WIDTH(AW)) bus ();

    pe_depacketizer #(.FILTER_WIDTH(FW), .ADDR_WIDTH(AW), .PE_ADDR(PA)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .filter_done (filter_done),
        .drop_cnt    (drop_cnt)
    );

    ent_t exp_q[$];
    int   m_row;
    int   m_drop;
    logic exp_done;
    logic exp_rdy;
    logic obs_rdy;
    int   errors = 0;
    int   checks = 0;

    function automatic logic [PW-1:0] mkpkt(input int dst, input logic typ, input logic [DW-1:0] pay);
        logic [AW-1:0] d;
        d = AW'(dst);
        return {d, typ, pay};
    endfunction

    // Drives one cycle from a negedge, samples in_ready before the edge, advances the model.
    task automatic step(input logic v, input logic [PW-1:0] p, input logic ordy);
        logic [AW-1:0] d;
        logic          typ;
        logic [DW-1:0] pay;
        ent_t          e;
        bus.in_valid  = v;
        bus.pkt_in    = p;
        bus.out_ready = ordy;
        #1;
        obs_rdy = bus.in_ready;
        exp_rdy = (exp_q.size() < 2) || ordy;
        d   = p[PW-1 -: AW];
        typ = p[DW];
        pay = p[DW-1:0];
        exp_done = 1'b0;
        if (exp_q.size() != 0 && ordy) void'(exp_q.pop_front());
        if (v && exp_rdy) begin
            if (int'(d) == PA) begin
                if (!typ) begin
                    e.data = pay & 24'h0001FF; e.flag = 1'b0; e.row = 2'd0;
                end else begin
                    e.data = pay; e.flag = 1'b1; e.row = 2'(m_row);
                    if (m_row == 2) exp_done = 1'b1;
                    m_row = (m_row + 1) % 3;
                end
                exp_q.push_back(e);
            end else if (m_drop < 255) begin
                m_drop++;
            end
        end
        @(negedge clk);
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_row = 0;
        m_drop = 0;
        exp_done = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b1;
        bus.pkt_in = mkpkt(PA, 1'b1, 24'h123456);
        bus.out_ready = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.data_out !== 24'd0) begin errors++; $display("FAIL reset_data got=%h exp=0", bus.data_out); end
        checks++; if (bus.ifmapb_filter_out !== 1'b0 || bus.filter_row_out !== 2'd0) begin
            errors++; $display("FAIL reset_flag_row got=%b/%0d exp=0/0", bus.ifmapb_filter_out, bus.filter_row_out); end
        checks++; if (filter_done !== 1'b0 || drop_cnt !== 8'd0) begin
            errors++; $display("FAIL reset_done_drop got=%b/%0d exp=0/0", filter_done, drop_cnt); end
        rst = 1'b0;
        bus.in_valid = 1'b0;
        model_reset();
    endtask

    task automatic test_filter_seq();
        logic [DW-1:0] pay [3];
        int pulses = 0;
        pay[0] = 24'h010203; pay[1] = 24'h040506; pay[2] = 24'h070809;
        for (int i = 0; i < 5; i++) begin
            if (i < 3) step(1'b1, mkpkt(PA, 1'b1, pay[i]), 1'b1);
            else       step(1'b0, '0, 1'b1);
            pulses += int'(filter_done);
            if (i < 3) begin
                checks++; if (obs_rdy !== 1'b1) begin errors++; $display("FAIL filt_in_ready[%0d] got=%b exp=1", i, obs_rdy); end
                checks++; if (bus.out_valid !== 1'b1 || bus.data_out !== pay[i] || bus.ifmapb_filter_out !== 1'b1 || bus.filter_row_out !== 2'(i)) begin
                    errors++; $display("FAIL filt_out[%0d] got v=%b d=%h f=%b r=%0d exp v=1 d=%h f=1 r=%0d",
                        i, bus.out_valid, bus.data_out, bus.ifmapb_filter_out, bus.filter_row_out, pay[i], i); end
            end else begin
                checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL filt_drain[%0d] got=%b exp=0", i, bus.out_valid); end
            end
            checks++; if (filter_done !== (i == 2)) begin errors++; $display("FAIL filt_done[%0d] got=%b exp=%b", i, filter_done, (i == 2)); end
        end
        checks++; if (pulses != 1) begin errors++; $display("FAIL filt_pulses got=%0d exp=1", pulses); end
    endtask

    task automatic test_ifmap();
        step(1'b1, mkpkt(PA, 1'b0, 24'hFFFFFF), 1'b1);
        checks++; if (bus.out_valid !== 1'b1 || bus.data_out !== 24'h0001FF || bus.ifmapb_filter_out !== 1'b0 || bus.filter_row_out !== 2'd0) begin
            errors++; $display("FAIL ifmap_out got v=%b d=%h f=%b r=%0d exp v=1 d=0001ff f=0 r=0",
                bus.out_valid, bus.data_out, bus.ifmapb_filter_out, bus.filter_row_out); end
        step(1'b0, '0, 1'b1);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL ifmap_drain got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_interleave();
        logic [DW-1:0] pay [4];
        logic          typ [4];
        logic [1:0]    row [4];
        int pulses = 0;
        pay[0] = 24'hA1A2A3; typ[0] = 1'b1; row[0] = 2'd0;
        pay[1] = 24'h00017E; typ[1] = 1'b0; row[1] = 2'd0;
        pay[2] = 24'hB1B2B3; typ[2] = 1'b1; row[2] = 2'd1;
        pay[3] = 24'hC1C2C3; typ[3] = 1'b1; row[3] = 2'd2;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) step(1'b1, mkpkt(PA, typ[i], pay[i]), 1'b1);
            else       step(1'b0, '0, 1'b1);
            pulses += int'(filter_done);
            if (i < 4) begin
                checks++; if (bus.data_out !== pay[i] || bus.ifmapb_filter_out !== typ[i] || bus.filter_row_out !== row[i]) begin
                    errors++; $display("FAIL ileave_out[%0d] got d=%h f=%b r=%0d exp d=%h f=%b r=%0d",
                        i, bus.data_out, bus.ifmapb_filter_out, bus.filter_row_out, pay[i], typ[i], row[i]); end
            end
        end
        checks++; if (pulses != 1) begin errors++; $display("FAIL ileave_pulses got=%0d exp=1", pulses); end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] pay [3];
        for (int i = 0; i < 3; i++) pay[i] = DW'($urandom_range(0, 511));
        step(1'b1, mkpkt(PA, 1'b0, pay[0]), 1'b0);
        step(1'b1, mkpkt(PA, 1'b0, pay[1]), 1'b0);
        step(1'b1, mkpkt(PA, 1'b0, pay[2]), 1'b0);
        checks++; if (obs_rdy !== 1'b0) begin errors++; $display("FAIL bp_full_ready got=%b exp=0", obs_rdy); end
        checks++; if (bus.out_valid !== 1'b1 || bus.data_out !== pay[0]) begin
            errors++; $display("FAIL bp_hold got v=%b d=%h exp v=1 d=%h", bus.out_valid, bus.data_out, pay[0]); end
        step(1'b1, mkpkt(PA, 1'b0, pay[2]), 1'b1);
        checks++; if (obs_rdy !== 1'b1) begin errors++; $display("FAIL bp_pop_ready got=%b exp=1", obs_rdy); end
        checks++; if (bus.data_out !== pay[1]) begin errors++; $display("FAIL bp_second got=%h exp=%h", bus.data_out, pay[1]); end
        step(1'b0, '0, 1'b1);
        checks++; if (bus.out_valid !== 1'b1 || bus.data_out !== pay[2]) begin
            errors++; $display("FAIL bp_third got v=%b d=%h exp v=1 d=%h", bus.out_valid, bus.data_out, pay[2]); end
        step(1'b0, '0, 1'b1);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_drop();
        int bad = 0;
        for (int i = 0; i < 300; i++) begin
            step(1'b1, mkpkt(PA + 1, 1'($urandom_range(0, 1)), DW'($urandom)), 1'b1);
            checks++; if (obs_rdy !== 1'b1 || bus.out_valid !== 1'b0) begin
                errors++; bad++;
                if (bad < 5) $display("FAIL drop_cycle[%0d] got rdy=%b v=%b exp rdy=1 v=0", i, obs_rdy, bus.out_valid); end
        end
        checks++; if (drop_cnt !== 8'd255) begin errors++; $display("FAIL drop_sat got=%0d exp=255", drop_cnt); end
        step(1'b1, mkpkt(PA, 1'b1, 24'h5A5A5A), 1'b1);
        checks++; if (bus.out_valid !== 1'b1 || bus.filter_row_out !== 2'd0 || bus.data_out !== 24'h5A5A5A) begin
            errors++; $display("FAIL drop_row got v=%b r=%0d d=%h exp v=1 r=0 d=5a5a5a", bus.out_valid, bus.filter_row_out, bus.data_out); end
        step(1'b0, '0, 1'b1);
    endtask

    task automatic test_mid_reset();
        // Row counter is 1 on entry (one filter row sent at the end of the drop test).
        step(1'b1, mkpkt(PA, 1'b1, 24'h111111), 1'b1);
        step(1'b1, mkpkt(PA, 1'b1, 24'h222222), 1'b1);
        checks++; if (bus.out_valid !== 1'b1 || bus.filter_row_out !== 2'(exp_q[0].row)) begin
            errors++; $display("FAIL mrst_pre got v=%b r=%0d exp v=1 r=%0d", bus.out_valid, bus.filter_row_out, exp_q[0].row); end
        rst = 1'b1;
        bus.in_valid = 1'b1;
        bus.pkt_in = mkpkt(PA, 1'b1, 24'h333333);
        bus.out_ready = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL mrst_in_ready got=%b exp=0", bus.in_ready); end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        checks++; if (bus.out_valid !== 1'b0 || drop_cnt !== 8'd0 || filter_done !== 1'b0) begin
            errors++; $display("FAIL mrst_post got v=%b drop=%0d done=%b exp 0/0/0", bus.out_valid, drop_cnt, filter_done); end
        step(1'b1, mkpkt(PA, 1'b1, 24'h444444), 1'b1);
        checks++; if (bus.out_valid !== 1'b1 || bus.filter_row_out !== 2'd0 || bus.data_out !== 24'h444444) begin
            errors++; $display("FAIL mrst_row got v=%b r=%0d d=%h exp v=1 r=0 d=444444", bus.out_valid, bus.filter_row_out, bus.data_out); end
        step(1'b0, '0, 1'b1);
    endtask

    task automatic test_random();
        int bad = 0;
        for (int i = 0; i < 500; i++) begin
            int d;
            d = ($urandom_range(0, 9) < 8) ? PA : int'($urandom_range(1, 15));
            step(1'($urandom_range(0, 9) < 7), mkpkt(d, 1'($urandom_range(0, 1)), DW'($urandom)),
                 1'($urandom_range(0, 9) < 6));
            checks++;
            if (obs_rdy !== exp_rdy || bus.out_valid !== (exp_q.size() != 0) || filter_done !== exp_done ||
                drop_cnt !== 8'(m_drop) ||
                (exp_q.size() != 0 && {bus.data_out, bus.ifmapb_filter_out, bus.filter_row_out} !== exp_q[0])) begin
                errors++; bad++;
                if (bad < 6)
                    $display("FAIL rand[%0d] got rdy=%b v=%b done=%b drop=%0d head=%h exp rdy=%b v=%b done=%b drop=%0d head=%h",
                        i, obs_rdy, bus.out_valid, filter_done, drop_cnt,
                        {bus.data_out, bus.ifmapb_filter_out, bus.filter_row_out},
                        exp_rdy, (exp_q.size() != 0), exp_done, m_drop, (exp_q.size() != 0) ? exp_q[0] : ent_t'(0));
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.pkt_in = '0;
        bus.out_ready = 1'b0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_filter_seq();
        test_ifmap();
        test_interleave();
        test_backpressure();
        test_drop();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
